// File: rtl/add_serial.sv
// add_serial: multi-cycle ripple adder/subtractor, DIGIT bits per clock.
//
// A WIDTH-bit operand pair is latched on an accepted start. It is then consumed
// LSB digit first through a DIGIT-bit full-adder chain. A registered carry links
// consecutive digits. N = WIDTH/DIGIT RUN cycles are followed by a single DONE cycle.
//
// Optional feature macro: ADD_SERIAL_OVERFLOW_EN
//   defined   -> overflow = carry into MSB XOR carry_out, registered with out
//   undefined -> overflow tied to 0, no extra flops
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   operation request, sampled in IDLE or DONE
//   sub        in   0 = add, 1 = subtract (latched with start)
//   a, b       in   WIDTH-bit operands (latched with start)
//   carry_in   in   carry into bit 0 for add, ignored for subtract
//   busy       out  operation in flight (RUN or DONE)
//   done       out  one-cycle pulse when out/carry_out update
//   out        out  WIDTH-bit result, held between done pulses
//   carry_out  out  carry out of bit WIDTH-1 (1 = no borrow on subtract)
//   overflow   out  signed overflow flag
module add_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               cout_q, cout_d;
    logic               accept;

    // Digit adder outputs
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
`ifdef ADD_SERIAL_OVERFLOW_EN
    logic               dig_cmsb;
    logic               ovf_q, ovf_d;
`endif

    // Single-bit full-adder cell; the digit chain is DIGIT of these in series
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

    // DIGIT-bit ripple chain on the low digit of the operand shift registers
    always_comb begin
        logic       c;
        logic [1:0] fa;
        dig_sum = '0;
        c       = carry_q;
        fa      = '0;
`ifdef ADD_SERIAL_OVERFLOW_EN
        dig_cmsb = 1'b0;
`endif
        for (int unsigned i = 0; i < DIGIT; i++) begin
`ifdef ADD_SERIAL_OVERFLOW_EN
            // Carry into the top bit of this digit; only used on the final digit
            if (i == DIGIT - 1) begin
                dig_cmsb = c;
            end
`endif
            fa         = full_adder(a_q[i], b_q[i], c);
            dig_sum[i] = fa[0];
            c          = fa[1];
        end
        dig_cout = c;
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        cout_d  = cout_q;
`ifdef ADD_SERIAL_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            RUN: begin
                // Operands shift down so the active digit is always at bit 0;
                // the result fills in from the top so it is aligned after N digits.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_DIGIT) begin
                    state_d = DONE;
                    out_d   = res_d;
                    cout_d  = dig_cout;
`ifdef ADD_SERIAL_OVERFLOW_EN
                    ovf_d   = dig_cmsb ^ dig_cout;
`endif
                end
            end
            DONE: begin
                if (start) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Subtract is a + ~b + 1: invert b here and force the initial carry
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | carry_in;
            count_d = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ADD_SERIAL_OVERFLOW_EN
    // Overflow flag register, updated together with out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_add_serial.sv
// Bench for add_serial (WIDTH=16, DIGIT=4): table vectors plus handshake corner cases,
// with results checked through an expected-value queue popped on each done pulse.
module tb_add_serial;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int LAT = 5;
`ifdef ADD_SERIAL_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sub = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              carry_in = 1'b0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  out;
    logic              carry_out;
    logic              overflow;

    add_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .out(out),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [15:0] eo;
        logic        ec;
        logic        ev;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: two's complement add with signed overflow by operand/result signs
    function automatic exp_t model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
        exp_t        e;
        logic [15:0] yy;
        logic [16:0] t;
        yy     = s ? ~y : y;
        t      = {1'b0, x} + {1'b0, yy} + 17'(s ? 1'b1 : ci);
        e.res  = t[15:0];
        e.cout = t[16];
        e.ovf  = OVF_ON & (x[15] == yy[15]) & (t[15] != x[15]);
        return e;
    endfunction

    // Scoreboard: each done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out", 32'(out), 32'(e.res));
                check("carry_out", 32'(carry_out), 32'(e.cout));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    // Drive one start for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input exp_t e);
        @(negedge clk);
        sub = s; a = x; b = y; carry_in = ci; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full operation with latency, busy-length and return-to-idle checks
    task automatic run_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input exp_t e);
        int lat;
        int bcnt;
        issue(s, x, y, ci, e);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        check("latency", 32'(lat), 32'(LAT));
        check("busy_cycles", 32'(bcnt), 32'(LAT));
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   d0;
        int   lat;
        exp_t e;
        logic [15:0] rx;
        logic [15:0] ry;
        logic        rs;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, OVF_ON};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, OVF_ON};
        vecs[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 16'hA5A5, 16'h0F0F, 1'b0, 16'hB4B4, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            e.res  = vecs[i].eo;
            e.cout = vecs[i].ec;
            e.ovf  = vecs[i].ev;
            run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].ci, e);
        end

        // start during RUN is ignored: one done, first operation's result
        d0 = done_cnt;
        issue(1'b0, 16'h0100, 16'h0023, 1'b0, '{16'h0123, 1'b0, 1'b0});
        @(negedge clk);
        sub = 1'b1; a = 16'hDEAD; b = 16'hBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("run_start_done_count", 32'(done_cnt - d0), 32'd1);

        // start held high: back-to-back results every N+1 cycles
        d0 = done_cnt;
        @(negedge clk);
        rs = 1'b0; rx = 16'h1111; ry = 16'h2222;
        sub = rs; a = rx; b = ry; carry_in = 1'b1; start = 1'b1;
        sb_q.push_back(model(rs, rx, ry, 1'b1));
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!done && lat < 20);
            check("b2b_latency", 32'(lat), 32'(LAT));
            check("b2b_busy", 32'(busy), 32'd1);
            if (i < 3) begin
                rs = 1'($urandom_range(1)); rx = 16'($urandom); ry = 16'($urandom);
                sub = rs; a = rx; b = ry;
                sb_q.push_back(model(rs, rx, ry, 1'b1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd4);
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset during RUN aborts immediately
        d0 = done_cnt;
        issue(1'b0, 16'h1357, 16'h2468, 1'b0, '{16'h37BF, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        check("abort_carry_out", 32'(carry_out), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/add_serial.md
# add_serial

Parametrised multi-cycle ripple adder/subtractor for the arithmetic group. It processes a WIDTH-bit operand pair DIGIT bits per clock, built from a chain of DIGIT single-bit full-adder cells plus a registered carry between digits. It trades latency for area in the wider ALU datapaths. A start/busy/done handshake lets a sequencer issue back-to-back operations.

## Interface

- WIDTH, 16: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits added per cycle, in the range 1..WIDTH; N = WIDTH/DIGIT cycles per operation.

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the block can accept.
- sub  in  1  0 = add, 1 = subtract; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- carry_in  in  1  carry into bit 0 for add; ignored when sub=1.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when out/carry_out are updated.
- out  out  WIDTH  result; holds its value between done pulses.
- carry_out  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow flag; see Configuration.

## Operation

- States: IDLE, RUN, DONE. Reset puts the block in IDLE and clears the digit counter, carry register and operand/shift registers.
- Reset values: busy=0, done=0, out=0, carry_out=0, overflow=0.
- Accept: start=1 sampled in IDLE or DONE.
  - Latches a, b (b inverted when sub=1) and sub.
  - Carry register loads carry_in when sub=0, or 1 when sub=1.
  - Counter is set to 0. Next state is RUN.
- start while in RUN is ignored. No queueing and no error indication.
- RUN, each cycle:
  - Adds digit[count] of A and B' with the carry register, LSB digit first.
  - Writes the DIGIT-bit sum into the internal result register and stores the new carry.
  - Increments count.
  - After digit N-1, the next state is DONE.
- DONE, single cycle:
  - done=1. out, carry_out and overflow take the final values on the edge that enters DONE.
  - Next state is RUN if start=1, otherwise IDLE.
- Arithmetic:
  - sub=0: out = (a + b + carry_in) mod 2^WIDTH.
  - sub=1: out = (a + ~b + 1) mod 2^WIDTH. carry_out=1 means no borrow.
- out, carry_out and overflow change only on the edge entering DONE. Intermediate digits are never visible on out.
- Reset asserted mid-operation aborts it immediately. Outputs return to reset values and the partial result is discarded.

## Timing

- Start sampled at edge k, then RUN covers edges k+1..k+N.
- done is high during the cycle following edge k+N. Latency is N+1 cycles from the start edge to done.
- busy is high from the cycle after the start edge through the done cycle inclusive. busy=0 in IDLE only.
- Back-to-back: start=1 during the DONE cycle gives a new done exactly N+1 cycles later, with no idle gap. Throughput is one result per N+1 cycles.
- DIGIT=WIDTH degenerates to N=1, with done 2 cycles after start.
- Combinational depth per cycle is a DIGIT-bit ripple chain; no other long paths are permitted.

## Configuration

- ADD_SERIAL_OVERFLOW_EN defined:
  - Keeps the carry into the MSB of the final digit.
  - overflow = carry_into_msb XOR carry_out, registered with out.
- Not defined:
  - overflow is tied to 0 and no extra flops are generated.
  - The port remains present so instantiations do not change.

## Test plan

All scenarios use WIDTH=16, DIGIT=4.

- Add 0x1234 + 0x4321, carry_in=0 -> out=0x5555, carry_out=0, done pulses 5 cycles after the start edge, busy high for 5 cycles.
- Add 0xFFFF + 0x0001, carry_in=0 -> out=0x0000, carry_out=1, overflow=0. Add 0x7FFF + 0x0001 -> out=0x8000, carry_out=0, overflow=1 (overflow=0 without ADD_SERIAL_OVERFLOW_EN).
- Subtract 0x0005 - 0x0007 with carry_in=1 (ignored) -> out=0xFFFE, carry_out=0. Subtract 0x0007 - 0x0005 -> out=0x0002, carry_out=1.
- Start pulsed again in RUN cycle 2 with different operands -> ignored; result is that of the first operation and only one done pulse occurs.
- start held high continuously with operand changes at each DONE -> done every 5 cycles, each out matching the operands latched at the preceding accept.
- rst_n low during RUN cycle 3 -> busy, done and out are 0 immediately. After release, IDLE; a fresh 0x0001 + 0x0001 gives out=0x0002.
